reorder_buffer: RTL and testbench

- 16-entry in-order retirement buffer that sits directly upstream of the register file's retirement write port.
- Receives up to 4 dispatched instructions per cycle from the instruction buffer and returns one ROB tag (the "owner" id) per slot.
- Captures results from 2 execution writeback ports.
- Retires up to 4 completed instructions per cycle in program order. It drives retirement_write_data_enable/target_reg/write_data/instruction_writer into the register file.

---
 rtl/rob_pkg.sv | 24 ++
 rtl/rob_retire_select.sv | 32 +++
 rtl/reorder_buffer.sv | 155 +++++++++++++++
 tb/tb_reorder_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared sizing constants and entry/tag types for the reorder buffer
// No ports; imported by reorder_buffer and rob_retire_select.
package rob_pkg;

   localparam int ENTRIES  = 16;
   localparam int TAG_W    = 4;
   localparam int WIDTH    = 4;
   localparam int DATA_W   = 16;
   localparam int REG_W    = 4;
   localparam int WB_PORTS = 2;
   localparam int CNT_W    = TAG_W + 1;   // must hold 0..ENTRIES inclusive
   localparam int K_W      = 3;           // retire count 0..WIDTH

   typedef logic [TAG_W-1:0] rob_tag_t;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              has_dest;
      logic [REG_W-1:0]  target_reg;
      logic [DATA_W-1:0] data;
   } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// rtl/rob_retire_select.sv - counts retirable entries starting at head, capped at WIDTH
// Ports:
//   ready_vec  in   per-entry (valid & done), bit n = entry n
//   head       in   oldest entry pointer
//   k          out  number of consecutive ready entries from head (0..WIDTH)
module rob_retire_select
   import rob_pkg::*;
(
   input  logic [ENTRIES-1:0] ready_vec,
   input  rob_tag_t           head,
   output logic [K_W-1:0]     k
);

   logic     run;
   rob_tag_t idx;

   // Only the first WIDTH positions of the rotated window matter; the index
   // wraps naturally in TAG_W bits.
   always_comb begin
      k   = '0;
      run = 1'b1;
      idx = head;
      for (int i = 0; i < WIDTH; i++) begin
         idx = head + rob_tag_t'(i);
         run = run & ready_vec[idx];
         if (run) begin
            k = k + K_W'(1);
         end
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 16-entry in-order retirement buffer feeding the regfile retire port
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   alloc_valid/has_dest/target_reg  dispatch slots, slot 0 (oldest) in the MSB field
//   alloc_ready, alloc_tag_flat      dispatch accept and per-slot tag (combinational)
//   wb_valid/tag/data_flat           execution writeback, port 0 in the MSB field
//   flush                            synchronous squash of all entries
//   retirement_* / instruction_writer_flat  registered retire lanes, lane 0 = MSB = oldest
//   rob_count, rob_empty             occupancy
module reorder_buffer
   import rob_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           alloc_valid_flat,
   input  logic [WIDTH-1:0]           alloc_has_dest_flat,
   input  logic [WIDTH*REG_W-1:0]     alloc_target_reg_flat,
   output logic                       alloc_ready,
   output logic [WIDTH*TAG_W-1:0]     alloc_tag_flat,
   input  logic [WB_PORTS-1:0]        wb_valid_flat,
   input  logic [WB_PORTS*TAG_W-1:0]  wb_tag_flat,
   input  logic [WB_PORTS*DATA_W-1:0] wb_data_flat,
   input  logic                       flush,
   output logic [WIDTH-1:0]           retirement_write_data_enable_flat,
   output logic [WIDTH*REG_W-1:0]     retirement_target_reg_flat,
   output logic [WIDTH*DATA_W-1:0]    retirement_write_data_flat,
   output logic [WIDTH*TAG_W-1:0]     instruction_writer_flat,
   output logic [CNT_W-1:0]           rob_count,
   output logic                       rob_empty
);

   rob_entry_t          rob_q [ENTRIES];
   rob_tag_t            head_q;
   rob_tag_t            tail_q;
   logic [CNT_W-1:0]    count_q;

   logic [ENTRIES-1:0]  ready_vec;
   logic [K_W-1:0]      retire_k;
   logic [K_W-1:0]      alloc_n;
   logic                alloc_fire;
   rob_tag_t            slot_tag [WIDTH];
   rob_tag_t            lane_tag [WIDTH];
   rob_tag_t            wb_tag   [WB_PORTS];
   logic [DATA_W-1:0]   wb_data  [WB_PORTS];

   always_comb begin
      ready_vec = '0;
      for (int e = 0; e < ENTRIES; e++) begin
         ready_vec[e] = rob_q[e].valid & rob_q[e].done;
      end
   end

   rob_retire_select u_retire_select (
      .ready_vec (ready_vec),
      .head      (head_q),
      .k         (retire_k)
   );

   // Conservative: ignores entries that may retire this same cycle.
   assign alloc_ready = (count_q <= CNT_W'(ENTRIES - WIDTH));
   assign alloc_fire  = alloc_ready && (alloc_valid_flat != '0);
   assign rob_count   = count_q;
   assign rob_empty   = (count_q == '0);

   // Valid slots are packed onto consecutive tags; gaps consume no entry.
   always_comb begin
      alloc_n        = '0;
      alloc_tag_flat = '0;
      for (int i = 0; i < WIDTH; i++) begin
         slot_tag[i] = tail_q + rob_tag_t'(alloc_n);
         alloc_tag_flat[(WIDTH-1-i)*TAG_W +: TAG_W] = slot_tag[i];
         if (alloc_valid_flat[WIDTH-1-i]) begin
            alloc_n = alloc_n + K_W'(1);
         end
      end
   end

   always_comb begin
      for (int l = 0; l < WIDTH; l++) begin
         lane_tag[l] = head_q + rob_tag_t'(l);
      end
      for (int p = 0; p < WB_PORTS; p++) begin
         wb_tag[p]  = wb_tag_flat[(WB_PORTS-1-p)*TAG_W +: TAG_W];
         wb_data[p] = wb_data_flat[(WB_PORTS-1-p)*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q                            <= '0;
         tail_q                            <= '0;
         count_q                           <= '0;
         retirement_write_data_enable_flat <= '0;
         retirement_target_reg_flat        <= '0;
         retirement_write_data_flat        <= '0;
         instruction_writer_flat           <= '0;
         for (int e = 0; e < ENTRIES; e++) begin
            rob_q[e] <= '0;
         end
      end else if (flush) begin
         head_q                            <= '0;
         tail_q                            <= '0;
         count_q                           <= '0;
         retirement_write_data_enable_flat <= '0;
         retirement_target_reg_flat        <= '0;
         retirement_write_data_flat        <= '0;
         instruction_writer_flat           <= '0;
         for (int e = 0; e < ENTRIES; e++) begin
            rob_q[e] <= '0;
         end
      end else begin
         // Highest port first so port 0's write lands last and wins a tag collision.
         for (int p = WB_PORTS-1; p >= 0; p--) begin
            if (wb_valid_flat[WB_PORTS-1-p] && rob_q[wb_tag[p]].valid) begin
               rob_q[wb_tag[p]].done <= 1'b1;
               rob_q[wb_tag[p]].data <= wb_data[p];
            end
         end

         for (int l = 0; l < WIDTH; l++) begin
            if (K_W'(l) < retire_k) begin
               retirement_write_data_enable_flat[WIDTH-1-l]          <= rob_q[lane_tag[l]].has_dest;
               retirement_target_reg_flat[(WIDTH-1-l)*REG_W +: REG_W] <= rob_q[lane_tag[l]].target_reg;
               retirement_write_data_flat[(WIDTH-1-l)*DATA_W +: DATA_W] <= rob_q[lane_tag[l]].data;
               instruction_writer_flat[(WIDTH-1-l)*TAG_W +: TAG_W]    <= lane_tag[l];
               rob_q[lane_tag[l]].valid <= 1'b0;
               rob_q[lane_tag[l]].done  <= 1'b0;
            end else begin
               retirement_write_data_enable_flat[WIDTH-1-l]          <= 1'b0;
               retirement_target_reg_flat[(WIDTH-1-l)*REG_W +: REG_W] <= '0;
               retirement_write_data_flat[(WIDTH-1-l)*DATA_W +: DATA_W] <= '0;
               instruction_writer_flat[(WIDTH-1-l)*TAG_W +: TAG_W]    <= '0;
            end
         end

         // Allocated entries are free slots at tail, never the retiring ones at head.
         if (alloc_fire) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (alloc_valid_flat[WIDTH-1-i]) begin
                  rob_q[slot_tag[i]] <= '{valid:      1'b1,
                                          done:       1'b0,
                                          has_dest:   alloc_has_dest_flat[WIDTH-1-i],
                                          target_reg: alloc_target_reg_flat[(WIDTH-1-i)*REG_W +: REG_W],
                                          data:       '0};
               end
            end
            tail_q <= tail_q + rob_tag_t'(alloc_n);
         end

         head_q  <= head_q + rob_tag_t'(retire_k);
         count_q <= count_q + CNT_W'(alloc_fire ? alloc_n : K_W'(0)) - CNT_W'(retire_k);
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed scoreboard bench for reorder_buffer
module tb_reorder_buffer;
   import rob_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  alloc_valid_flat;
   logic [3:0]  alloc_has_dest_flat;
   logic [15:0] alloc_target_reg_flat;
   logic        alloc_ready;
   logic [15:0] alloc_tag_flat;
   logic [1:0]  wb_valid_flat;
   logic [7:0]  wb_tag_flat;
   logic [31:0] wb_data_flat;
   logic        flush;
   logic [3:0]  retirement_write_data_enable_flat;
   logic [15:0] retirement_target_reg_flat;
   logic [63:0] retirement_write_data_flat;
   logic [15:0] instruction_writer_flat;
   logic [4:0]  rob_count;
   logic        rob_empty;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk                               (clk),
      .rst_n                             (rst_n),
      .alloc_valid_flat                  (alloc_valid_flat),
      .alloc_has_dest_flat               (alloc_has_dest_flat),
      .alloc_target_reg_flat             (alloc_target_reg_flat),
      .alloc_ready                       (alloc_ready),
      .alloc_tag_flat                    (alloc_tag_flat),
      .wb_valid_flat                     (wb_valid_flat),
      .wb_tag_flat                       (wb_tag_flat),
      .wb_data_flat                      (wb_data_flat),
      .flush                             (flush),
      .retirement_write_data_enable_flat (retirement_write_data_enable_flat),
      .retirement_target_reg_flat        (retirement_target_reg_flat),
      .retirement_write_data_flat        (retirement_write_data_flat),
      .instruction_writer_flat           (instruction_writer_flat),
      .rob_count                         (rob_count),
      .rob_empty                         (rob_empty)
   );

   int          checks = 0;
   int          errors = 0;
   logic [23:0] sb [$];          // {reg, data, tag} in expected retirement order
   logic [3:0]  reg_of [16];
   logic [23:0] mon_got;
   logic [23:0] mon_exp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] r, input logic [15:0] d, input logic [3:0] t);
      sb.push_back({r, d, t});
   endtask

   task automatic dispatch(input logic [3:0] v, input logic [3:0] hd, input logic [15:0] regs,
                           input logic [15:0] exp_tags, input logic exp_ready);
      logic [15:0] mask;
      alloc_valid_flat      = v;
      alloc_has_dest_flat   = hd;
      alloc_target_reg_flat = regs;
      #1;
      check("alloc_ready", {63'd0, alloc_ready}, {63'd0, exp_ready});
      if (exp_ready) begin
         for (int i = 0; i < 4; i++) mask[i*4 +: 4] = {4{v[i]}};
         check("alloc_tag", {48'd0, alloc_tag_flat & mask}, {48'd0, exp_tags & mask});
      end
      step();
      alloc_valid_flat = '0;
   endtask

   task automatic wb(input logic [1:0] v, input logic [3:0] t0, input logic [15:0] d0,
                     input logic [3:0] t1, input logic [15:0] d1);
      wb_valid_flat = v;
      wb_tag_flat   = {t0, t1};
      wb_data_flat  = {d0, d1};
      step();
      wb_valid_flat = '0;
   endtask

   // Retirement monitor: every enabled lane, oldest first, must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int l = 0; l < 4; l++) begin
            if (retirement_write_data_enable_flat[3-l]) begin
               mon_got = {retirement_target_reg_flat[(3-l)*4 +: 4],
                          retirement_write_data_flat[(3-l)*16 +: 16],
                          instruction_writer_flat[(3-l)*4 +: 4]};
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_retire lane%0d: actual %0h expected none", l, mon_got);
               end else begin
                  mon_exp = sb.pop_front();
                  check($sformatf("retire_lane%0d", l), {40'd0, mon_got}, {40'd0, mon_exp});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reg_of = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8,
                 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd1};
      rst_n = 1'b0;
      flush = 1'b0;
      alloc_valid_flat = '0;
      alloc_has_dest_flat = '0;
      alloc_target_reg_flat = '0;
      wb_valid_flat = '0;
      wb_tag_flat = '0;
      wb_data_flat = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_count", rob_count, 0);
      check("reset_empty", rob_empty, 1);
      check("reset_ret_en", retirement_write_data_enable_flat, 0);
      check("reset_ready", alloc_ready, 1);
      rst_n = 1'b1;
      step();

      // Four in-order dispatches, then a sparse pair (slot 2 has no destination).
      dispatch(4'b1111, 4'b1111, 16'h1234, 16'h0123, 1'b1);
      check("count_4", rob_count, 4);
      check("ready_4", alloc_ready, 1);
      dispatch(4'b1010, 4'b1000, 16'h5060, 16'h4050, 1'b1);
      check("count_6", rob_count, 6);

      // Out-of-order completion: tag 1 first, then tag 0 releases both.
      wb(2'b10, 4'd1, 16'h0046, 4'd0, 16'h0000);
      check("no_retire_gap", retirement_write_data_enable_flat, 0);
      push(4'd1, 16'h0005, 4'd0);
      push(4'd2, 16'h0046, 4'd1);
      wb(2'b10, 4'd0, 16'h0005, 4'd0, 16'h0000);
      step();
      check("pair_ret_en", retirement_write_data_enable_flat, 4'b1100);
      check("count_after_pair", rob_count, 4);

      // Both ports hit tag 2; port 0 data must be what retires.
      push(4'd3, 16'h1111, 4'd2);
      wb(2'b11, 4'd2, 16'h1111, 4'd2, 16'h2222);
      step();
      check("collide_ret_en", retirement_write_data_enable_flat, 4'b1000);
      check("count_3", rob_count, 3);

      // Fill to 16, wrapping tail 15 -> 0.
      dispatch(4'b1000, 4'b1000, 16'h7000, 16'h6000, 1'b1);
      dispatch(4'b1111, 4'b1111, 16'h89AB, 16'h789A, 1'b1);
      dispatch(4'b1111, 4'b1111, 16'hCDEF, 16'hBCDE, 1'b1);
      check("count_12", rob_count, 12);
      dispatch(4'b1111, 4'b1111, 16'h1234, 16'hF012, 1'b1);
      check("count_16", rob_count, 16);
      check("full_not_ready", alloc_ready, 0);
      dispatch(4'b1111, 4'b1111, 16'h1111, 16'h0000, 1'b0);
      check("full_hold", rob_count, 16);

      // Retire 3,4 then 5 (no dest) and 6.
      push(4'd4, 16'h0300, 4'd3);
      push(4'd5, 16'h0400, 4'd4);
      push(4'd7, 16'h0600, 4'd6);
      wb(2'b11, 4'd3, 16'h0300, 4'd4, 16'h0400);
      wb(2'b11, 4'd5, 16'h0500, 4'd6, 16'h0600);
      check("drain1_en", retirement_write_data_enable_flat, 4'b1100);
      check("count_14", rob_count, 14);
      step();
      check("nodest_en", retirement_write_data_enable_flat, 4'b0100);
      check("count_12b", rob_count, 12);

      // Count 13 blocks dispatch.
      dispatch(4'b1000, 4'b1000, 16'h5000, 16'h3000, 1'b1);
      check("count_13", rob_count, 13);
      dispatch(4'b1111, 4'b1111, 16'h2222, 16'h0000, 1'b0);
      check("hold_13", rob_count, 13);

      // Drain 7..F,0..3: complete ahead of head, then a 4-wide retire capped at WIDTH.
      for (int i = 0; i < 13; i++) begin
         logic [3:0] t;
         t = 4'(7 + i);
         push(reg_of[t], 16'hB000 | {12'd0, t}, t);
      end
      wb(2'b11, 4'h8, 16'hB008, 4'h9, 16'hB009);
      wb(2'b11, 4'hA, 16'hB00A, 4'hB, 16'hB00B);
      wb(2'b11, 4'hC, 16'hB00C, 4'hD, 16'hB00D);
      wb(2'b10, 4'h7, 16'hB007, 4'h0, 16'h0000);
      step();
      check("cap4_en", retirement_write_data_enable_flat, 4'b1111);
      check("count_9", rob_count, 9);
      wb(2'b11, 4'hE, 16'hB00E, 4'hF, 16'hB00F);
      wb(2'b11, 4'h0, 16'hB000, 4'h1, 16'hB001);
      wb(2'b11, 4'h2, 16'hB002, 4'h3, 16'hB003);
      repeat (4) step();
      check("drained_count", rob_count, 0);
      check("drained_empty", rob_empty, 1);

      // Flush with 8 live entries, a pending writeback and a dispatch in the same cycle.
      dispatch(4'b1111, 4'b1111, 16'h1234, 16'h4567, 1'b1);
      dispatch(4'b1111, 4'b1111, 16'h5678, 16'h89AB, 1'b1);
      check("count_8", rob_count, 8);
      wb(2'b11, 4'd5, 16'hC005, 4'd6, 16'hC006);
      flush = 1'b1;
      alloc_valid_flat = 4'b1111;
      wb_valid_flat = 2'b10;
      wb_tag_flat = {4'd4, 4'd0};
      wb_data_flat = {16'hC004, 16'h0000};
      step();
      flush = 1'b0;
      alloc_valid_flat = '0;
      wb_valid_flat = '0;
      check("flush_count", rob_count, 0);
      check("flush_empty", rob_empty, 1);
      check("flush_ret_en", retirement_write_data_enable_flat, 0);
      step();
      check("post_flush_ret_en", retirement_write_data_enable_flat, 0);
      dispatch(4'b1000, 4'b1000, 16'h9000, 16'h0000, 1'b1);
      push(4'd9, 16'h00AB, 4'd0);
      wb(2'b10, 4'd0, 16'h00AB, 4'd0, 16'h0000);
      step();
      check("final_count", rob_count, 0);
      step();
      check("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
